// File: rtl/mac_operand_sequencer.sv
// mac_operand_sequencer: front-end feeder for the SIMD multiprecision MAC.
// Accepts a valid/ready stream of operand pairs terminated by a last flag.
// FP8 pairs are issued one per beat. FP4 pairs are packed two per byte, with
// lane0 in [7:4]. The block then waits out the MAC pipeline, returns the
// captured accumulator on a valid/ready result port and clears the MAC.
// Optional feature: define MAC_OPSEQ_PERF_CNT_EN to add the issue_cnt and
// stall_cnt performance counters.
module mac_operand_sequencer #(
  parameter int PIPE_LAT = 3,
  parameter int CNT_W    = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       mode_in,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_a,
  input  logic [7:0] in_b,
  input  logic       in_last,
  output logic [7:0] mac_a,
  output logic [7:0] mac_b,
  output logic       mac_sel,
  output logic       mac_rst_n,
  input  logic [7:0] mac_out,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [7:0] res_data,
  output logic       res_mode
`ifdef MAC_OPSEQ_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] issue_cnt,
  output logic [CNT_W-1:0] stall_cnt
`endif
);

  typedef enum logic [2:0] {IDLE, HALF, WAIT, RESULT, CLEAR} state_t;

  localparam logic [3:0] WaitLast = 4'(PIPE_LAT - 1);

  state_t     state;
  logic [3:0] lane0_a;
  logic [3:0] lane0_b;
  logic [3:0] wait_cnt;
  logic       in_vec;
  logic       xfer;
  logic       eff_mode;
  logic       issue;

  // Mode in force for the current beat (latched once a vector is underway),
  // and whether the accepted beat produces a MAC issue on the next cycle.
  always_comb begin
    xfer     = in_valid && in_ready;
    eff_mode = in_vec ? mac_sel : mode_in;
    issue    = 1'b0;
    if (xfer) begin
      if (state == HALF)
        issue = 1'b1;
      else if (state == IDLE)
        issue = !eff_mode || in_last;
    end
  end

  // Sequencer FSM with registered MAC drive, handshake and result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b0;
      mac_a     <= 8'h00;
      mac_b     <= 8'h00;
      mac_sel   <= 1'b0;
      mac_rst_n <= 1'b0;
      res_valid <= 1'b0;
      res_data  <= 8'h00;
      res_mode  <= 1'b0;
      lane0_a   <= 4'h0;
      lane0_b   <= 4'h0;
      wait_cnt  <= 4'h0;
      in_vec    <= 1'b0;
    end else begin
      mac_a     <= 8'h00;
      mac_b     <= 8'h00;
      mac_rst_n <= 1'b1;
      case (state)
        IDLE: begin
          in_ready <= 1'b1;
          if (xfer) begin
            if (!in_vec)
              mac_sel <= mode_in;
            if (!eff_mode) begin
              mac_a <= in_a;
              mac_b <= in_b;
            end else begin
              lane0_a <= in_a[3:0];
              lane0_b <= in_b[3:0];
              if (in_last) begin
                mac_a <= {in_a[3:0], 4'h0};
                mac_b <= {in_b[3:0], 4'h0};
              end
            end
            if (in_last) begin
              state    <= WAIT;
              in_ready <= 1'b0;
              in_vec   <= 1'b0;
              wait_cnt <= 4'h0;
            end else begin
              in_vec <= 1'b1;
              if (eff_mode)
                state <= HALF;
            end
          end
        end
        HALF: begin
          in_ready <= 1'b1;
          if (xfer) begin
            mac_a <= {lane0_a, in_a[3:0]};
            mac_b <= {lane0_b, in_b[3:0]};
            if (in_last) begin
              state    <= WAIT;
              in_ready <= 1'b0;
              in_vec   <= 1'b0;
              wait_cnt <= 4'h0;
            end else begin
              state <= IDLE;
            end
          end
        end
        WAIT: begin
          in_ready <= 1'b0;
          if (wait_cnt == WaitLast) begin
            res_data  <= mac_out;
            res_mode  <= mac_sel;
            res_valid <= 1'b1;
            state     <= RESULT;
          end else begin
            wait_cnt <= wait_cnt + 4'h1;
          end
        end
        RESULT: begin
          in_ready <= 1'b0;
          if (res_valid && res_ready) begin
            res_valid <= 1'b0;
            mac_rst_n <= 1'b0;
            state     <= CLEAR;
          end
        end
        CLEAR: begin
          in_ready <= 1'b1;
          state    <= IDLE;
        end
        default: begin
          in_ready <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

`ifdef MAC_OPSEQ_PERF_CNT_EN
  // Saturating counters of MAC issues and of stalled input cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      issue_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      if (issue && (issue_cnt != {CNT_W{1'b1}}))
        issue_cnt <= issue_cnt + 1'b1;
      if (in_valid && !in_ready && (stall_cnt != {CNT_W{1'b1}}))
        stall_cnt <= stall_cnt + 1'b1;
    end
  end
`else
  logic unused_perf;
  assign unused_perf = (CNT_W == 0) ^ issue;
`endif

endmodule

// File: tb/tb_mac_operand_sequencer.sv
// tb_mac_operand_sequencer: directed self-checking bench for the MAC operand
// sequencer (PIPE_LAT=3). Expected values are hand-computed constants.
module tb_mac_operand_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       mode_in;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_a;
  logic [7:0] in_b;
  logic       in_last;
  logic [7:0] mac_a;
  logic [7:0] mac_b;
  logic       mac_sel;
  logic       mac_rst_n;
  logic [7:0] mac_out;
  logic       res_valid;
  logic       res_ready;
  logic [7:0] res_data;
  logic       res_mode;
`ifdef MAC_OPSEQ_PERF_CNT_EN
  logic [15:0] issue_cnt;
  logic [15:0] stall_cnt;
`endif

  int total = 0;
  int bad   = 0;

  mac_operand_sequencer #(.PIPE_LAT(3), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .mode_in(mode_in), .in_valid(in_valid),
    .in_ready(in_ready), .in_a(in_a), .in_b(in_b), .in_last(in_last),
    .mac_a(mac_a), .mac_b(mac_b), .mac_sel(mac_sel), .mac_rst_n(mac_rst_n),
    .mac_out(mac_out), .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_mode(res_mode)
`ifdef MAC_OPSEQ_PERF_CNT_EN
    , .issue_cnt(issue_cnt), .stall_cnt(stall_cnt)
`endif
  );

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic v, input logic m, input logic [7:0] a,
                               input logic [7:0] b, input logic l);
    in_valid = v;
    mode_in  = m;
    in_a     = a;
    in_b     = b;
    in_last  = l;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  initial begin
    rst       = 1'b1;
    res_ready = 1'b0;
    mac_out   = 8'h5A;
    applyStimulus(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    step();
    step();
    checkOutput("rst_in_ready", 32'(in_ready), 32'h0);
    checkOutput("rst_mac_rst_n", 32'(mac_rst_n), 32'h0);
    checkOutput("rst_res_valid", 32'(res_valid), 32'h0);
    checkOutput("rst_mac_a", 32'(mac_a), 32'h0);
    checkOutput("rst_res_data", 32'(res_data), 32'h0);
    rst = 1'b0;
    step();
    checkOutput("rel_in_ready", 32'(in_ready), 32'h1);
    checkOutput("rel_mac_rst_n", 32'(mac_rst_n), 32'h1);

    $display("[TB] FP8 two-beat vector");
    applyStimulus(1'b1, 1'b0, 8'h38, 8'h40, 1'b0);
    step();
    checkOutput("fp8_i1_a", 32'(mac_a), 32'h38);
    checkOutput("fp8_i1_b", 32'(mac_b), 32'h40);
    checkOutput("fp8_sel", 32'(mac_sel), 32'h0);
    applyStimulus(1'b1, 1'b0, 8'h3C, 8'h38, 1'b1);
    step();
    checkOutput("fp8_i2_a", 32'(mac_a), 32'h3C);
    checkOutput("fp8_i2_b", 32'(mac_b), 32'h38);
    checkOutput("fp8_wait_ready", 32'(in_ready), 32'h0);
    applyStimulus(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    step();
    checkOutput("fp8_idle_a", 32'(mac_a), 32'h0);
    checkOutput("fp8_w1_valid", 32'(res_valid), 32'h0);
    step();
    checkOutput("fp8_w2_valid", 32'(res_valid), 32'h0);
    step();
    checkOutput("fp8_res_valid", 32'(res_valid), 32'h1);
    checkOutput("fp8_res_data", 32'(res_data), 32'h5A);
    checkOutput("fp8_res_mode", 32'(res_mode), 32'h0);

    $display("[TB] result held with res_ready low");
    mac_out = 8'h00;
    for (int i = 0; i < 10; i++) begin
      step();
      checkOutput("hold_valid", 32'(res_valid), 32'h1);
      checkOutput("hold_data", 32'(res_data), 32'h5A);
      checkOutput("hold_ready", 32'(in_ready), 32'h0);
    end
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    checkOutput("clr_res_valid", 32'(res_valid), 32'h0);
    checkOutput("clr_mac_rst_n", 32'(mac_rst_n), 32'h0);
    checkOutput("clr_in_ready", 32'(in_ready), 32'h0);
    step();
    checkOutput("post_clr_rst_n", 32'(mac_rst_n), 32'h1);
    checkOutput("post_clr_ready", 32'(in_ready), 32'h1);

    $display("[TB] FP4 three-beat vector with mode toggled mid-vector");
    mac_out = 8'hC3;
    applyStimulus(1'b1, 1'b1, 8'h03, 8'h05, 1'b0);
    step();
    checkOutput("fp4_half_a", 32'(mac_a), 32'h0);
    checkOutput("fp4_sel", 32'(mac_sel), 32'h1);
    checkOutput("fp4_half_ready", 32'(in_ready), 32'h1);
    applyStimulus(1'b1, 1'b0, 8'h07, 8'h02, 1'b0);
    step();
    checkOutput("fp4_i1_a", 32'(mac_a), 32'h37);
    checkOutput("fp4_i1_b", 32'(mac_b), 32'h52);
    checkOutput("fp4_sel_hold1", 32'(mac_sel), 32'h1);
    applyStimulus(1'b1, 1'b0, 8'h04, 8'h06, 1'b1);
    step();
    checkOutput("fp4_pad_a", 32'(mac_a), 32'h40);
    checkOutput("fp4_pad_b", 32'(mac_b), 32'h60);
    checkOutput("fp4_sel_hold2", 32'(mac_sel), 32'h1);
    applyStimulus(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    step();
    step();
    checkOutput("fp4_w2_valid", 32'(res_valid), 32'h0);
    step();
    checkOutput("fp4_res_valid", 32'(res_valid), 32'h1);
    checkOutput("fp4_res_data", 32'(res_data), 32'hC3);
    checkOutput("fp4_res_mode", 32'(res_mode), 32'h1);
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    checkOutput("fp4_clr_rst_n", 32'(mac_rst_n), 32'h0);
    step();
    checkOutput("fp4_post_ready", 32'(in_ready), 32'h1);

    $display("[TB] reset while holding lane0 in HALF");
    applyStimulus(1'b1, 1'b1, 8'h09, 8'h0A, 1'b0);
    step();
    checkOutput("half_sel", 32'(mac_sel), 32'h1);
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    step();
    checkOutput("hrst_rst_n", 32'(mac_rst_n), 32'h0);
    checkOutput("hrst_mac_a", 32'(mac_a), 32'h0);
    checkOutput("hrst_res_valid", 32'(res_valid), 32'h0);
    checkOutput("hrst_sel", 32'(mac_sel), 32'h0);
    rst = 1'b0;
    step();
    checkOutput("hrst_ready", 32'(in_ready), 32'h1);
    mac_out = 8'h77;
    applyStimulus(1'b1, 1'b0, 8'h11, 8'h22, 1'b1);
    step();
    checkOutput("after_rst_a", 32'(mac_a), 32'h11);
    checkOutput("after_rst_b", 32'(mac_b), 32'h22);
    checkOutput("after_rst_sel", 32'(mac_sel), 32'h0);
    applyStimulus(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    step();
    checkOutput("after_rst_idle_a", 32'(mac_a), 32'h0);
    step();
    step();
    checkOutput("after_rst_valid", 32'(res_valid), 32'h1);
    checkOutput("after_rst_data", 32'(res_data), 32'h77);
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    step();
    checkOutput("after_rst_ready", 32'(in_ready), 32'h1);

`ifdef MAC_OPSEQ_PERF_CNT_EN
    $display("[TB] performance counters");
    rst = 1'b1;
    step();
    rst = 1'b0;
    checkOutput("perf_rst_issue", 32'(issue_cnt), 32'h0);
    checkOutput("perf_rst_stall", 32'(stall_cnt), 32'h0);
    step();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 1'b0, 8'(i + 1), 8'(i + 2), (i == 3));
      step();
    end
    applyStimulus(1'b1, 1'b0, 8'hAA, 8'hBB, 1'b0);
    for (int i = 0; i < 5; i++)
      step();
    applyStimulus(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    checkOutput("perf_issue", 32'(issue_cnt), 32'd4);
    checkOutput("perf_stall", 32'(stall_cnt), 32'd5);
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    step();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
